// File: rtl/obstacle_queue.sv
// Scrolling cactus queue: spawns at the right edge and retires off the left edge as pos advances.
// cactus_on and hit are registered one cycle after their query inputs; halt freezes spawn, retire and the LFSR.
module obstacle_queue #(
    parameter int SCREEN_W = 640,
    parameter int CACTUS_W = 16,
    parameter int CACTUS_H = 32,
    parameter int GROUND_Y = 400,
    parameter int DINO_X   = 64,
    parameter int DINO_W   = 20,
    parameter int DINO_H   = 40,
    parameter int MIN_GAP  = 200,
    parameter int DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        restart,
    input  logic        halt,
    input  logic [10:0] pos,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic [9:0]  dino_y,
    output logic        cactus_on,
    output logic        hit,
    output logic [2:0]  count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic signed [11:0] CW12   = 12'(CACTUS_W);
    localparam logic signed [11:0] CY_TOP = 12'(GROUND_Y - CACTUS_H);
    localparam logic signed [11:0] CY_BOT = 12'(GROUND_Y);
    localparam logic signed [11:0] DX_L   = 12'(DINO_X);
    localparam logic signed [11:0] DX_R   = 12'(DINO_X + DINO_W);
    localparam logic signed [11:0] DH12   = 12'(DINO_H);

    typedef enum logic [1:0] {S_EMPTY, S_RUN, S_HALTED} state_t;

    state_t            state;
    logic [10:0]       slot_x [DEPTH];
    logic [DEPTH-1:0]  slot_vld;
    logic [PW-1:0]     head, tail, tail_last;
    logic [10:0]       pos_q;
    logic [7:0]        lfsr;

    logic              step, active, retire, spawn, lfsr_fb;
    logic [10:0]       head_edge, tail_sx, spawn_lim;
    logic [2:0]        cnt_nxt;
    logic              on_nxt, hit_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign step      = (pos != pos_q);
    assign active    = step && !halt && (state != S_HALTED);
    assign tail_last = (tail == '0) ? PW'(DEPTH - 1) : tail - 1'b1;
    assign head_edge = slot_x[head] + 11'(CACTUS_W) - pos;
    assign tail_sx   = slot_x[tail_last] - pos;
    assign spawn_lim = 11'(SCREEN_W - MIN_GAP) - {4'd0, lfsr[6:0]};
    assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    // head_edge >= 1024 means bit 10 set: the right edge of the head cactus has left the screen
    assign retire = active && (count != 3'd0) && (head_edge >= 11'd1024);
    // a retiring head frees its slot, so a full queue can still accept a spawn in the same step
    assign spawn  = active && ((count == 3'd0) ||
                    (((count < 3'(DEPTH)) || retire) && (tail_sx <= spawn_lim)));
    assign cnt_nxt = count + {2'd0, spawn} - {2'd0, retire};

    always_comb begin
        logic signed [11:0] sx, px, py, dy;
        logic [10:0] d;
        logic pix_band, dino_band;
        on_nxt  = 1'b0;
        hit_nxt = 1'b0;
        sx = '0;
        d  = '0;
        px = signed'({2'b00, pixel_x});
        py = signed'({2'b00, pixel_y});
        dy = signed'({2'b00, dino_y});
        pix_band  = (py >= CY_TOP) && (py < CY_BOT);
        dino_band = (dy < CY_BOT) && ((dy + DH12) > CY_TOP);
        for (int i = 0; i < DEPTH; i++) begin
            d  = slot_x[i] - pos;
            sx = signed'({d[10], d});
            if (slot_vld[i] && pix_band && (px >= sx) && (px < sx + CW12))
                on_nxt = 1'b1;
            if (slot_vld[i] && dino_band && (sx < DX_R) && ((sx + CW12) > DX_L))
                hit_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (spawn)
            slot_x[tail] <= pos + 11'(SCREEN_W);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_EMPTY;
            head      <= '0;
            tail      <= '0;
            count     <= 3'd0;
            slot_vld  <= '0;
            pos_q     <= 11'd0;
            lfsr      <= LFSR_SEED;
            cactus_on <= 1'b0;
            hit       <= 1'b0;
        end else begin
            pos_q <= pos;
            if (restart) begin
                state     <= S_EMPTY;
                head      <= '0;
                tail      <= '0;
                count     <= 3'd0;
                slot_vld  <= '0;
                lfsr      <= LFSR_SEED;
                cactus_on <= 1'b0;
                hit       <= 1'b0;
            end else begin
                cactus_on <= on_nxt;
                hit       <= hit_nxt;
                if (state == S_HALTED) begin
                    if (!halt)
                        state <= (count == 3'd0) ? S_EMPTY : S_RUN;
                end else if (halt) begin
                    state <= S_HALTED;
                end else if (step) begin
                    lfsr <= {lfsr[6:0], lfsr_fb};
                    if (retire) begin
                        slot_vld[head] <= 1'b0;
                        head           <= ptr_inc(head);
                    end
                    if (spawn) begin
                        slot_vld[tail] <= 1'b1;
                        tail           <= ptr_inc(tail);
                    end
                    count <= cnt_nxt;
                    state <= (cnt_nxt == 3'd0) ? S_EMPTY : S_RUN;
                end
            end
        end
    end
endmodule

// File: tb/tb_obstacle_queue.sv
// Bench for obstacle_queue: directed scenarios plus randomized scrolling against a queue-based model.
module tb_obstacle_queue;
    logic        clk = 1'b0;
    logic        reset_n, restart, halt;
    logic [10:0] pos;
    logic [9:0]  pixel_x, pixel_y, dino_y;
    logic        cactus_on, hit;
    logic [2:0]  count;

    int n_checks = 0;
    int n_pass   = 0;

    // model: world x of each live cactus, oldest first
    int mq[$];
    int m_lfsr;
    int m_posq;
    bit m_halted;
    bit exp_on, exp_hit;

    obstacle_queue dut (
        .clk(clk), .reset_n(reset_n), .restart(restart), .halt(halt), .pos(pos),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .dino_y(dino_y),
        .cactus_on(cactus_on), .hit(hit), .count(count)
    );

    always #5 clk = ~clk;

    function automatic int scr_x(input int wx, input int p);
        int d;
        d = (wx - p) & 2047;
        return (d >= 1024) ? d - 2048 : d;
    endfunction

    function automatic int spawn_lim();
        return 640 - 200 - (m_lfsr & 127);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_lfsr   = 8'hA5;
        m_posq   = 0;
        m_halted = 1'b0;
        exp_on   = 1'b0;
        exp_hit  = 1'b0;
    endtask

    // one clock edge: predict registered outputs and queue update from the current inputs
    task automatic tick();
        int p, px, py, dy, s;
        bit ret, spw;
        p  = int'(pos);
        px = int'(pixel_x);
        py = int'(pixel_y);
        dy = int'(dino_y);
        exp_on  = 1'b0;
        exp_hit = 1'b0;
        foreach (mq[i]) begin
            s = scr_x(mq[i], p);
            if (px >= s && px < s + 16 && py >= 400 - 32 && py < 400) exp_on = 1'b1;
            if (s < 64 + 20 && s + 16 > 64 && dy < 400 && dy + 40 > 400 - 32) exp_hit = 1'b1;
        end
        if (restart) begin
            mq.delete();
            m_lfsr   = 8'hA5;
            m_halted = 1'b0;
            exp_on   = 1'b0;
            exp_hit  = 1'b0;
        end else if (m_halted) begin
            m_halted = halt;
        end else if (halt) begin
            m_halted = 1'b1;
        end else if (p != m_posq) begin
            ret = 1'b0;
            if (mq.size() > 0) ret = (((mq[0] + 16 - p) & 2047) >= 1024);
            if (mq.size() == 0) spw = 1'b1;
            else spw = (mq.size() < 4 || ret) && (((mq[$] - p) & 2047) <= spawn_lim());
            if (ret) mq.delete(0);
            if (spw) mq.push_back((p + 640) & 2047);
            m_lfsr = ((m_lfsr << 1) | int'(^(m_lfsr & 8'hB8))) & 255;
        end
        m_posq = p;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        restart = 1'b0;
        halt    = 1'b0;
        pos     = 11'd0;
        pixel_x = 10'd0;
        pixel_y = 10'd0;
        dino_y  = 10'd0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
        n_checks++; if (cactus_on !== 1'b0) $display("FAIL reset_cactus_on: got %b want 0", cactus_on); else n_pass++;
        n_checks++; if (hit !== 1'b0) $display("FAIL reset_hit: got %b want 0", hit); else n_pass++;
    endtask

    task automatic test_first_spawn();
        do_reset();
        pos = 11'd2; tick();
        n_checks++; if (count !== 3'd1) $display("FAIL first_spawn_count: got %0d want 1", count); else n_pass++;
        pixel_x = 10'd640; pixel_y = 10'd380; tick();
        n_checks++; if (cactus_on !== 1'b1) $display("FAIL first_spawn_x642: got %b want 1", cactus_on); else n_pass++;
        pixel_x = 10'd639; tick();
        n_checks++; if (cactus_on !== 1'b0) $display("FAIL first_spawn_left: got %b want 0", cactus_on); else n_pass++;
    endtask

    task automatic test_query();
        do_reset();
        pos = 11'd2; tick();
        pos = 11'd342; tick();
        pixel_x = 10'd300; pixel_y = 10'd380; tick();
        n_checks++; if (cactus_on !== 1'b1) $display("FAIL query_300_380: got %b want 1", cactus_on); else n_pass++;
        pixel_x = 10'd316; tick();
        n_checks++; if (cactus_on !== 1'b0) $display("FAIL query_316_380: got %b want 0", cactus_on); else n_pass++;
        pixel_x = 10'd300; pixel_y = 10'd367; tick();
        n_checks++; if (cactus_on !== 1'b0) $display("FAIL query_300_367: got %b want 0", cactus_on); else n_pass++;
        pixel_x = 10'd315; pixel_y = 10'd399; tick();
        n_checks++; if (cactus_on !== 1'b1) $display("FAIL query_315_399: got %b want 1", cactus_on); else n_pass++;
    endtask

    task automatic test_retire();
        do_reset();
        pos = 11'd2; tick();
        pos = 11'd658; tick();
        n_checks++; if (count !== 3'd1) $display("FAIL retire_edge_kept: got %0d want 1", count); else n_pass++;
        pos = 11'd660; tick();
        n_checks++; if (count !== 3'd0) $display("FAIL retire_count: got %0d want 0", count); else n_pass++;
        pos = 11'd662; tick();
        n_checks++; if (count !== 3'd1) $display("FAIL retire_respawn: got %0d want 1", count); else n_pass++;
    endtask

    task automatic test_hit_halt();
        int saved;
        do_reset();
        pos = 11'd2; tick();
        dino_y = 10'd340;
        pos = 11'd558; tick();
        n_checks++; if (hit !== 1'b0) $display("FAIL hit_x_touch: got %b want 0", hit); else n_pass++;
        pos = 11'd559; tick();
        n_checks++; if (hit !== 1'b1) $display("FAIL hit_x_overlap: got %b want 1", hit); else n_pass++;
        pos = 11'd572; tick();
        n_checks++; if (hit !== 1'b1) $display("FAIL hit_340: got %b want 1", hit); else n_pass++;
        dino_y = 10'd328; tick();
        n_checks++; if (hit !== 1'b0) $display("FAIL hit_328: got %b want 0", hit); else n_pass++;
        dino_y = 10'd329; tick();
        n_checks++; if (hit !== 1'b1) $display("FAIL hit_329: got %b want 1", hit); else n_pass++;
        saved = mq.size();
        halt = 1'b1; tick();
        for (int k = 0; k < 10; k++) begin
            pos = pos + 11'd2; tick();
            n_checks++;
            if (count !== 3'(saved)) $display("FAIL halt_count_%0d: got %0d want %0d", k, count, saved);
            else n_pass++;
        end
        halt = 1'b0; tick();
        for (int k = 0; k < 40; k++) begin
            pos = pos + 11'd2; tick();
            n_checks++;
            if (count !== 3'(mq.size())) $display("FAIL post_halt_count_%0d: got %0d want %0d", k, count, mq.size());
            else n_pass++;
        end
    endtask

    task automatic test_full();
        int j, guard;
        do_reset();
        pos = 11'd2; tick();
        for (int k = 0; k < 3; k++) begin
            guard = 0;
            while ((m_lfsr & 127) > 18 && guard < 90) begin
                pos = pos + 11'd2; tick(); guard++;
            end
            j = ((mq[$] - int'(pos)) & 2047) - spawn_lim();
            if (j > 0) begin pos = pos + 11'(j); tick(); end
        end
        n_checks++; if (count !== 3'd4) $display("FAIL full_count: got %0d want 4", count); else n_pass++;
        j = ((mq[$] - int'(pos)) & 2047) - spawn_lim();
        pos = pos + 11'(j); tick();
        n_checks++; if (count !== 3'd4) $display("FAIL full_retire_spawn: got %0d want 4", count); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            pos = pos + 11'd2; tick();
            n_checks++;
            if (count !== 3'(mq.size())) $display("FAIL full_after_%0d: got %0d want %0d", k, count, mq.size());
            else n_pass++;
        end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        pos = 11'd1428; tick();
        pos = 11'd2046; tick();
        pixel_x = 10'd20; pixel_y = 10'd380;
        pos = 11'd0; tick();
        n_checks++; if (count !== 3'd2) $display("FAIL wrap_count: got %0d want 2", count); else n_pass++;
        n_checks++; if (cactus_on !== 1'b1) $display("FAIL wrap_on_20: got %b want 1", cactus_on); else n_pass++;
        pixel_x = 10'd36; tick();
        n_checks++; if (cactus_on !== 1'b0) $display("FAIL wrap_on_36: got %b want 0", cactus_on); else n_pass++;
        pixel_x = 10'd35; dino_y = 10'd340; pos = 11'd2040; tick();
        reset_n = 1'b0;
        #2;
        n_checks++; if (count !== 3'd0) $display("FAIL async_count: got %0d want 0", count); else n_pass++;
        n_checks++; if (cactus_on !== 1'b0) $display("FAIL async_on: got %b want 0", cactus_on); else n_pass++;
        n_checks++; if (hit !== 1'b0) $display("FAIL async_hit: got %b want 0", hit); else n_pass++;
        pos = 11'd0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        pos = 11'd2; tick();
        n_checks++; if (count !== 3'd1) $display("FAIL post_reset_spawn: got %0d want 1", count); else n_pass++;
    endtask

    task automatic test_random();
        int s;
        for (int c = 0; c < 1500; c++) begin
            restart = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) halt = ~halt;
            if ($urandom_range(0, 9) < 7) pos = pos + 11'd2;
            if (mq.size() > 0 && $urandom_range(0, 1) == 1) begin
                s = scr_x(mq[$urandom_range(0, mq.size() - 1)], int'(pos)) + int'($urandom_range(0, 18)) - 1;
                if (s < 0) s = 0;
                if (s > 1023) s = 1023;
                pixel_x = 10'(s);
            end else begin
                pixel_x = 10'($urandom_range(0, 700));
            end
            pixel_y = 10'($urandom_range(360, 405));
            dino_y  = 10'($urandom_range(320, 400));
            tick();
            n_checks++;
            if (count !== 3'(mq.size())) $display("FAIL rnd_count_%0d: got %0d want %0d", c, count, mq.size());
            else n_pass++;
            n_checks++;
            if (cactus_on !== exp_on) $display("FAIL rnd_on_%0d: got %b want %b", c, cactus_on, exp_on);
            else n_pass++;
            n_checks++;
            if (hit !== exp_hit) $display("FAIL rnd_hit_%0d: got %b want %b", c, hit, exp_hit);
            else n_pass++;
        end
        restart = 1'b0;
        halt    = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_spawn();
        test_query();
        test_retire();
        test_hit_halt();
        test_full();
        test_wrap_and_reset();
        do_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/obstacle_queue.md
OBSTACLE_QUEUE -- requirements
Module: obstacle_queue

Interface
REQ-001 Parameters (name, default, meaning); sizes in pixels:
- SCREEN_W, 640, visible width
- CACTUS_W, 16, cactus width
- CACTUS_H, 32, cactus height
- GROUND_Y, 400, ground line
- DINO_X, 64, dino left edge
- DINO_W, 20, dino width
- DINO_H, 40, dino height
- MIN_GAP, 200, minimum spawn spacing
- DEPTH, 4, queue slots
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, system clock
- reset_n, in, 1, asynchronous active-low reset
- restart, in, 1, synchronous queue clear
- halt, in, 1, freeze spawn and retire
- pos, in, 11, scroll position; increases by 2 per step, wraps mod 2048
- pixel_x, in, 10, query column
- pixel_y, in, 10, query row
- dino_y, in, 10, dino top edge
- cactus_on, out, 1, query pixel lies in a cactus
- hit, out, 1, dino box overlaps a cactus
- count, out, 3, valid slots

Function
REQ-003 Store each obstacle's world x (11 bits) in a DEPTH-entry circular buffer with head, tail and count; oldest entry at head.
REQ-004 Compute screen x as (world_x - pos) mod 2048; all position arithmetic is 11-bit modular.
REQ-005 Define a step as any cycle with pos != pos_q, where pos_q is pos registered; spawn and retire evaluate only on steps.
REQ-006 FSM states:
- EMPTY: count=0; any step spawns, then go to RUN.
- RUN: retiring the last entry with no spawn returns to EMPTY; halt=1 goes to HALTED.
- HALTED: no spawn, no retire, LFSR frozen; halt=0 returns to RUN, or EMPTY if count=0.
REQ-007 Retire condition: on a step, retire head if ((head_x + CACTUS_W - pos) mod 2048) has bit 10 set, i.e. fully off the left edge.
REQ-008 Spawn condition: on a step, spawn if count=0, or if tail screen x <= SCREEN_W - gap, where gap = MIN_GAP + lfsr[6:0]. The new entry's world x = pos + SCREEN_W.
REQ-009 Retire and spawn in the same step are both performed; count is unchanged.
REQ-010 Full queue (count=DEPTH): spawn suppressed and re-evaluated on each later step; no entry is overwritten.
REQ-011 LFSR: 8-bit, polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5, advances once per step outside HALTED. gap uses the pre-advance value.
REQ-012 cactus_on is registered with 1-cycle latency. It is 1 iff some valid slot satisfies screen x <= pixel_x < screen x + CACTUS_W and GROUND_Y - CACTUS_H <= pixel_y < GROUND_Y. Served in every state.
REQ-013 hit is registered with 1-cycle latency and is a level, not sticky. It is 1 iff some valid slot's box overlaps the dino box, X [DINO_X, DINO_X+DINO_W) and Y [dino_y, dino_y+DINO_H), with strict overlap (edges touching = no hit).
REQ-014 Screen x with bit 10 set counts as off-screen-left for REQ-012/REQ-013 comparisons. Comparisons are signed 12-bit.
REQ-015 restart=1 on a clock edge: count, head and tail = 0; state = EMPTY; LFSR = seed; cactus_on and hit = 0 next cycle. restart has priority over spawn and retire.

Reset
REQ-016 reset_n=0 asynchronously forces: state EMPTY; count, head, tail = 0; pos_q = pos reset value 0; LFSR = 8'hA5; cactus_on, hit = 0.
REQ-017 Reset asserted mid-operation discards all entries. The first step after release behaves as from EMPTY.

Verification
REQ-018 Reset, then pos 0->2: one cycle later count=1, entry world x=642, state RUN.
REQ-019 Single entry at 642, step pos to 342: query (300,380) gives cactus_on=1 one cycle later; (316,380) gives 0; (300,367) gives 0.
REQ-020 Same entry, step pos 658->660: entry retires, count=0, state EMPTY, no spawn in that step unless count was 0 before the step.
REQ-021 Entry at screen x 70, dino_y=340 (bottom 380 > 368): hit=1. dino_y=328 (bottom 368): hit=0. halt=1 for 10 steps: count and LFSR unchanged.
REQ-022 Fill 4 slots, force a spawn condition: count stays 4. After the head retires, the next qualifying step spawns. Retire and spawn in the same step keep count=4.
REQ-023 Wrap case: entry spawned at pos=1428 (world x 20), pos 2046->0: screen x = 20, no spurious retire. Pulse reset_n low mid-run: all outputs 0 immediately.
